// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// slave = controller side, master = datapath side.
interface multicycle_controller_if #(
   parameter int STATE_W = 4
);
   // datapath -> controller
   logic [5:0]         op_code;
   logic [5:0]         func;
   logic               zero;
   logic               mem_ready;
   // controller -> datapath
   logic               ir_write;
   logic               pc_write;
   logic [1:0]         pc_src;
   logic               mem_req;
   logic               mem_we;
   logic               i_or_d;
   logic               reg_wr;
   logic [1:0]         reg_dst;
   logic [1:0]         mem_to_reg;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [2:0]         ALUCtr;
   logic [STATE_W-1:0] state;
   logic               illegal;

   modport slave (
      input  op_code, func, zero, mem_ready,
      output ir_write, pc_write, pc_src,
      output mem_req, mem_we, i_or_d,
      output reg_wr, reg_dst, mem_to_reg,
      output alu_src_a, alu_src_b, ALUCtr,
      output state, illegal
   );

   modport master (
      output op_code, func, zero, mem_ready,
      input  ir_write, pc_write, pc_src,
      input  mem_req, mem_we, i_or_d,
      input  reg_wr, reg_dst, mem_to_reg,
      input  alu_src_a, alu_src_b, ALUCtr,
      input  state, illegal
   );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle datapath: fetch, decode, exec, mem, wb.
// Ports: clk, rst (sync, active high), ctl (slave modport of the control bundle).
module multicycle_controller #(
   parameter int         STATE_W = 4,
   parameter logic [4:0] RA_REG  = 5'd31
) (
   input  logic clk,
   input  logic rst,
   multicycle_controller_if.slave ctl
);

   // RA_REG is consumed by the datapath's reg_dst mux (reg_dst = 2).
   if (STATE_W < 4) begin : g_bad_state_w
      $error("STATE_W must be at least 4");
   end
   if (RA_REG == 5'd0) begin : g_bad_ra
      $error("RA_REG must not be r0");
   end

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_EXEC_R = 4'd2;
   localparam logic [3:0] S_EXEC_I = 4'd3;
   localparam logic [3:0] S_WB_R   = 4'd4;
   localparam logic [3:0] S_WB_I   = 4'd5;
   localparam logic [3:0] S_MADDR  = 4'd6;
   localparam logic [3:0] S_MEM_RD = 4'd7;
   localparam logic [3:0] S_MEM_WR = 4'd8;
   localparam logic [3:0] S_WB_MEM = 4'd9;
   localparam logic [3:0] S_BRANCH = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;
   localparam logic [3:0] S_TRAP   = 4'd12;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_SLL = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_OR  = 3'b101;
   localparam logic [2:0] ALU_SLT = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   logic [3:0] r_state;
   logic [3:0] w_next;
   logic       r_illegal;

   // opcode classes
   logic       w_op_r, w_op_i, w_op_mem, w_op_br, w_op_j;
   logic       w_op_lw, w_op_bne, w_op_jal;
   logic [2:0] w_i_alu;
   // func classes
   logic       w_f_alu, w_f_jr;
   logic [2:0] w_f_ctr;

   assign w_op_r   = (ctl.op_code == 6'b000000);
   assign w_op_i   = (ctl.op_code == 6'b001000) ||
                     (ctl.op_code == 6'b001100) ||
                     (ctl.op_code == 6'b001101) ||
                     (ctl.op_code == 6'b001010) ||
                     (ctl.op_code == 6'b000001);
   assign w_op_lw  = (ctl.op_code == 6'b100011);
   assign w_op_mem = w_op_lw || (ctl.op_code == 6'b101011);
   assign w_op_bne = (ctl.op_code == 6'b000101);
   assign w_op_br  = w_op_bne || (ctl.op_code == 6'b000100);
   assign w_op_jal = (ctl.op_code == 6'b000011);
   assign w_op_j   = w_op_jal || (ctl.op_code == 6'b000010);

   always_comb begin
      w_i_alu = ALU_ADD;
      unique case (ctl.op_code)
         6'b001100: w_i_alu = ALU_AND;
         6'b001101: w_i_alu = ALU_OR;
         6'b001010: w_i_alu = ALU_SLT;
         default:   w_i_alu = ALU_ADD;
      endcase
   end

   always_comb begin
      w_f_alu = 1'b1;
      w_f_jr  = 1'b0;
      w_f_ctr = ALU_ADD;
      unique case (ctl.func)
         6'b100000: w_f_ctr = ALU_ADD;
         6'b100010: w_f_ctr = ALU_SUB;
         6'b100100: w_f_ctr = ALU_AND;
         6'b011000: w_f_ctr = ALU_OR;
         6'b101010: w_f_ctr = ALU_SLT;
         6'b000000: w_f_ctr = ALU_SLL;
         6'b000010: w_f_ctr = ALU_SRL;
         6'b001000: begin
            w_f_alu = 1'b0;
            w_f_jr  = 1'b1;
         end
         default:   w_f_alu = 1'b0;
      endcase
   end

   // state register; illegal latches on entry to TRAP
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next == S_TRAP) r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_FETCH:  if (ctl.mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               w_op_r:   w_next = S_EXEC_R;
               w_op_i:   w_next = S_EXEC_I;
               w_op_mem: w_next = S_MADDR;
               w_op_br:  w_next = S_BRANCH;
               w_op_j:   w_next = S_JUMP;
               default:  w_next = S_TRAP;
            endcase
         end
         S_EXEC_R: begin
            if (w_f_alu)     w_next = S_WB_R;
            else if (w_f_jr) w_next = S_FETCH;
            else             w_next = S_TRAP;
         end
         S_EXEC_I: w_next = S_WB_I;
         S_WB_R:   w_next = S_FETCH;
         S_WB_I:   w_next = S_FETCH;
         S_MADDR:  w_next = w_op_lw ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: if (ctl.mem_ready) w_next = S_WB_MEM;
         S_MEM_WR: if (ctl.mem_ready) w_next = S_FETCH;
         S_WB_MEM: w_next = S_FETCH;
         S_BRANCH: w_next = S_FETCH;
         S_JUMP:   w_next = S_FETCH;
         S_TRAP:   w_next = S_TRAP;
         default:  w_next = S_FETCH;
      endcase
   end

   logic       w_ir_write, w_pc_write, w_mem_req, w_mem_we, w_i_or_d;
   logic       w_reg_wr, w_alu_src_a;
   logic [1:0] w_pc_src, w_reg_dst, w_mem_to_reg, w_alu_src_b;
   logic [2:0] w_alu_ctr;

   always_comb begin
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_src     = 2'd0;
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_i_or_d     = 1'b0;
      w_reg_wr     = 1'b0;
      w_reg_dst    = 2'd0;
      w_mem_to_reg = 2'd0;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = 2'd0;
      w_alu_ctr    = ALU_ADD;
      unique case (r_state)
         S_FETCH: begin
            w_mem_req   = 1'b1;
            w_alu_src_b = 2'd1;
            w_ir_write  = ctl.mem_ready;
            w_pc_write  = ctl.mem_ready;
         end
         S_DECODE: w_alu_src_b = 2'd3;
         S_EXEC_R: begin
            w_alu_src_a = 1'b1;
            w_alu_ctr   = w_f_ctr;
            if (w_f_jr) begin
               w_pc_write = 1'b1;
               w_pc_src   = 2'd3;
            end
         end
         S_EXEC_I, S_MADDR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'd2;
            w_alu_ctr   = (r_state == S_EXEC_I) ? w_i_alu : ALU_ADD;
         end
         S_WB_R: begin
            w_reg_wr  = 1'b1;
            w_reg_dst = 2'd1;
         end
         S_WB_I: w_reg_wr = 1'b1;
         S_MEM_RD: begin
            w_mem_req = 1'b1;
            w_i_or_d  = 1'b1;
         end
         S_MEM_WR: begin
            w_mem_req = 1'b1;
            w_mem_we  = 1'b1;
            w_i_or_d  = 1'b1;
         end
         S_WB_MEM: begin
            w_reg_wr     = 1'b1;
            w_mem_to_reg = 2'd1;
         end
         S_BRANCH: begin
            w_alu_src_a = 1'b1;
            w_alu_ctr   = ALU_SUB;
            w_pc_src    = 2'd1;
            w_pc_write  = ctl.zero ^ w_op_bne;
         end
         S_JUMP: begin
            w_pc_write = 1'b1;
            w_pc_src   = 2'd2;
            if (w_op_jal) begin
               w_reg_wr     = 1'b1;
               w_reg_dst    = 2'd2;
               w_mem_to_reg = 2'd2;
            end
         end
         default: ;
      endcase
   end

   assign ctl.ir_write   = w_ir_write;
   assign ctl.pc_write   = w_pc_write;
   assign ctl.pc_src     = w_pc_src;
   assign ctl.mem_req    = w_mem_req;
   assign ctl.mem_we     = w_mem_we;
   assign ctl.i_or_d     = w_i_or_d;
   assign ctl.reg_wr     = w_reg_wr;
   assign ctl.reg_dst    = w_reg_dst;
   assign ctl.mem_to_reg = w_mem_to_reg;
   assign ctl.alu_src_a  = w_alu_src_a;
   assign ctl.alu_src_b  = w_alu_src_b;
   assign ctl.ALUCtr     = w_alu_ctr;
   assign ctl.state      = STATE_W'(r_state);
   assign ctl.illegal    = r_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver queues the
// expected control word per cycle, a monitor compares at the falling edge.
module tb_multicycle_controller;

   typedef struct packed {
      logic [3:0] st;
      logic       irw;
      logic       pcw;
      logic [1:0] pcs;
      logic       req;
      logic       we;
      logic       iod;
      logic       rw;
      logic [1:0] rdst;
      logic [1:0] m2r;
      logic       asa;
      logic [1:0] asb;
      logic [2:0] alu;
      logic       ill;
   } exp_t;

   localparam logic [3:0] S_F = 4'd0,  S_D = 4'd1,  S_XR = 4'd2;
   localparam logic [3:0] S_XI = 4'd3, S_WR = 4'd4, S_WI = 4'd5;
   localparam logic [3:0] S_MA = 4'd6, S_MR = 4'd7, S_MW = 4'd8;
   localparam logic [3:0] S_WM = 4'd9, S_BR = 4'd10, S_J = 4'd11;
   localparam logic [3:0] S_T = 4'd12;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_bad;
   exp_t  q[$];
   string qn[$];

   multicycle_controller_if #(.STATE_W(4)) bus ();

   multicycle_controller #(
      .STATE_W(4),
      .RA_REG (5'd31)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ctl(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, got timeout required $finish");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(
      input logic [3:0] st, input logic irw, input logic pcw,
      input logic [1:0] pcs, input logic req, input logic we,
      input logic iod, input logic rw, input logic [1:0] rdst,
      input logic [1:0] m2r, input logic asa, input logic [1:0] asb,
      input logic [2:0] alu, input logic ill);
      exp_t e;
      e = '{st, irw, pcw, pcs, req, we, iod, rw, rdst, m2r, asa, asb, alu, ill};
      return e;
   endfunction

   function automatic exp_t ef(input logic rdy);
      return mk(S_F, rdy, rdy, 2'd0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd1, 3'b000, 0);
   endfunction

   function automatic exp_t ed();
      return mk(S_D, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd3, 3'b000, 0);
   endfunction

   function automatic exp_t et();
      return mk(S_T, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'b000, 1);
   endfunction

   exp_t act;
   assign act = {bus.state, bus.ir_write, bus.pc_write, bus.pc_src,
                 bus.mem_req, bus.mem_we, bus.i_or_d, bus.reg_wr,
                 bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                 bus.alu_src_b, bus.ALUCtr, bus.illegal};

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t  e;
         string nm;
         e  = q.pop_front();
         nm = qn.pop_front();
         n_vec++;
         if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, e, $time);
         end
      end
   end

   task automatic cyc(input logic r, input logic [5:0] op,
                      input logic [5:0] fn, input logic z,
                      input logic rdy, input exp_t e, input string nm);
      @(posedge clk);
      #1;
      rst           = r;
      bus.op_code   = op;
      bus.func      = fn;
      bus.zero      = z;
      bus.mem_ready = rdy;
      q.push_back(e);
      qn.push_back(nm);
   endtask

   task automatic run_r(input logic [5:0] fn, input logic [2:0] alu,
                        input string nm);
      cyc(0, 6'b000000, fn, 0, 1, ef(1), {nm, "_fetch"});
      cyc(0, 6'b000000, fn, 0, 1, ed(), {nm, "_decode"});
      cyc(0, 6'b000000, fn, 0, 1,
          mk(S_XR, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, alu, 0),
          {nm, "_exec"});
      cyc(0, 6'b000000, fn, 0, 1,
          mk(S_WR, 0, 0, 2'd0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 2'd0, 3'b000, 0),
          {nm, "_wb"});
   endtask

   task automatic run_i(input logic [5:0] op, input logic [2:0] alu,
                        input string nm);
      cyc(0, op, 6'h3f, 0, 1, ef(1), {nm, "_fetch"});
      cyc(0, op, 6'h3f, 0, 1, ed(), {nm, "_decode"});
      cyc(0, op, 6'h3f, 0, 1,
          mk(S_XI, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, alu, 0),
          {nm, "_exec"});
      cyc(0, op, 6'h3f, 0, 1,
          mk(S_WI, 0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 2'd0, 3'b000, 0),
          {nm, "_wb"});
   endtask

   task automatic run_br(input logic [5:0] op, input logic z,
                         input logic pcw, input string nm);
      cyc(0, op, 6'h00, z, 1, ef(1), {nm, "_fetch"});
      cyc(0, op, 6'h00, z, 1, ed(), {nm, "_decode"});
      cyc(0, op, 6'h00, z, 1,
          mk(S_BR, 0, pcw, 2'd1, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, 3'b001, 0),
          {nm, "_branch"});
   endtask

   task automatic run_j(input logic [5:0] op, input logic link,
                        input string nm);
      logic [1:0] d;
      d = link ? 2'd2 : 2'd0;
      cyc(0, op, 6'h00, 0, 1, ef(1), {nm, "_fetch"});
      cyc(0, op, 6'h00, 0, 1, ed(), {nm, "_decode"});
      cyc(0, op, 6'h00, 0, 1,
          mk(S_J, 0, 1, 2'd2, 0, 0, 0, link, d, d, 0, 2'd0, 3'b000, 0),
          {nm, "_jump"});
   endtask

   typedef struct packed {
      logic [5:0] fn;
      logic [2:0] alu;
   } rvec_t;

   typedef struct packed {
      logic [5:0] op;
      logic [2:0] alu;
   } ivec_t;

   initial begin
      rvec_t rv[6];
      ivec_t iv[4];
      n_vec = 0;
      n_bad = 0;
      rst           = 1'b1;
      bus.op_code   = 6'b000000;
      bus.func      = 6'b100000;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);

      // reset held: FETCH, mem_req only, illegal clear
      cyc(1, 6'b000000, 6'b100000, 0, 0, ef(0), "reset");

      // add with mem_ready tied high
      run_r(6'b100000, 3'b000, "add");

      rv[0] = '{6'b100010, 3'b001};
      rv[1] = '{6'b100100, 3'b100};
      rv[2] = '{6'b011000, 3'b101};
      rv[3] = '{6'b101010, 3'b110};
      rv[4] = '{6'b000000, 3'b011};
      rv[5] = '{6'b000010, 3'b111};
      foreach (rv[i]) run_r(rv[i].fn, rv[i].alu, $sformatf("rtype%0d", i));

      iv[0] = '{6'b001000, 3'b000};
      iv[1] = '{6'b001100, 3'b100};
      iv[2] = '{6'b001101, 3'b101};
      iv[3] = '{6'b001010, 3'b110};
      foreach (iv[i]) run_i(iv[i].op, iv[i].alu, $sformatf("itype%0d", i));
      run_i(6'b000001, 3'b000, "li");

      // lw: 2 fetch waits, 3 read waits -> 10 cycles
      cyc(0, 6'b100011, 6'h00, 0, 0, ef(0), "lw_fwait0");
      cyc(0, 6'b100011, 6'h00, 0, 0, ef(0), "lw_fwait1");
      cyc(0, 6'b100011, 6'h00, 0, 1, ef(1), "lw_fetch");
      cyc(0, 6'b100011, 6'h00, 0, 0, ed(), "lw_decode");
      cyc(0, 6'b100011, 6'h00, 0, 0,
          mk(S_MA, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, 3'b000, 0),
          "lw_addr");
      for (int k = 0; k < 3; k++)
         cyc(0, 6'b100011, 6'h00, 0, 0,
             mk(S_MR, 0, 0, 2'd0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 2'd0, 3'b000, 0),
             $sformatf("lw_rwait%0d", k));
      cyc(0, 6'b100011, 6'h00, 0, 1,
          mk(S_MR, 0, 0, 2'd0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 2'd0, 3'b000, 0),
          "lw_rdone");
      cyc(0, 6'b100011, 6'h00, 0, 1,
          mk(S_WM, 0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 2'd1, 0, 2'd0, 3'b000, 0),
          "lw_wb");

      // sw with one write wait
      cyc(0, 6'b101011, 6'h00, 0, 1, ef(1), "sw_fetch");
      cyc(0, 6'b101011, 6'h00, 0, 1, ed(), "sw_decode");
      cyc(0, 6'b101011, 6'h00, 0, 1,
          mk(S_MA, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, 3'b000, 0),
          "sw_addr");
      cyc(0, 6'b101011, 6'h00, 0, 0,
          mk(S_MW, 0, 0, 2'd0, 1, 1, 1, 0, 2'd0, 2'd0, 0, 2'd0, 3'b000, 0),
          "sw_wait");
      cyc(0, 6'b101011, 6'h00, 0, 1,
          mk(S_MW, 0, 0, 2'd0, 1, 1, 1, 0, 2'd0, 2'd0, 0, 2'd0, 3'b000, 0),
          "sw_done");

      run_br(6'b000100, 1, 1, "beq_taken");
      run_br(6'b000100, 0, 0, "beq_not");
      run_br(6'b000101, 0, 1, "bne_taken");
      run_br(6'b000101, 1, 0, "bne_not");

      run_j(6'b000011, 1, "jal");
      run_j(6'b000010, 0, "j");

      // jr: 3 cycles, pc_src = rs
      cyc(0, 6'b000000, 6'b001000, 0, 1, ef(1), "jr_fetch");
      cyc(0, 6'b000000, 6'b001000, 0, 1, ed(), "jr_decode");
      cyc(0, 6'b000000, 6'b001000, 0, 1,
          mk(S_XR, 0, 1, 2'd3, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, 3'b000, 0),
          "jr_exec");

      // undefined opcode: TRAP held 20 cycles, mem_ready ignored
      cyc(0, 6'b111111, 6'h00, 0, 1, ef(1), "badop_fetch");
      cyc(0, 6'b111111, 6'h00, 0, 1, ed(), "badop_decode");
      for (int k = 0; k < 20; k++)
         cyc(0, 6'b111111, 6'h00, 1, 1, et(), $sformatf("badop_trap%0d", k));
      cyc(1, 6'b111111, 6'h00, 0, 1, et(), "badop_rst");

      // undefined func
      cyc(0, 6'b000000, 6'b111111, 0, 1, ef(1), "badfn_fetch");
      cyc(0, 6'b000000, 6'b111111, 0, 1, ed(), "badfn_decode");
      cyc(0, 6'b000000, 6'b111111, 0, 1,
          mk(S_XR, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, 3'b000, 0),
          "badfn_exec");
      for (int k = 0; k < 20; k++)
         cyc(0, 6'b000000, 6'b111111, 0, 1, et(), $sformatf("badfn_trap%0d", k));
      cyc(1, 6'b000000, 6'b111111, 0, 1, et(), "badfn_rst");
      cyc(0, 6'b000000, 6'b100000, 0, 0, ef(0), "after_trap_fetch");

      // rst during MEM_WR wait drops the write
      cyc(0, 6'b101011, 6'h00, 0, 1, ef(1), "swr_fetch");
      cyc(0, 6'b101011, 6'h00, 0, 1, ed(), "swr_decode");
      cyc(0, 6'b101011, 6'h00, 0, 0,
          mk(S_MA, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, 3'b000, 0),
          "swr_addr");
      cyc(1, 6'b101011, 6'h00, 0, 0,
          mk(S_MW, 0, 0, 2'd0, 1, 1, 1, 0, 2'd0, 2'd0, 0, 2'd0, 3'b000, 0),
          "swr_wait_rst");
      cyc(0, 6'b000000, 6'b100000, 0, 0, ef(0), "swr_after_rst");
      run_r(6'b100000, 3'b000, "add2");

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM that sequences a shared-memory, single-ALU multicycle datapath through fetch, decode, execute, memory and write-back, one instruction at a time.
- Decodes the team ISA (opcode plus R-type func) and drives the IR, PC, ALU, register-file and memory controls each cycle.
- Handshakes with a variable-latency memory and raises a sticky trap on undefined opcodes.

Parameters:
- STATE_W, 4, width of the exported state register.
- RA_REG, 5'd31, register written by jal.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op_code  in  6  IR[31:26]; datapath holds it stable while the IR is not written
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current request this cycle
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  load PC from the pc_src mux
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- reg_wr  out  1  register-file write enable
- reg_dst  out  2  0 = rt, 1 = rd, 2 = RA_REG
- mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC (already PC+4)
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2
- ALUCtr  out  3  000 add, 001 sub, 011 sll, 100 and, 101 or, 110 slt, 111 srl
- state  out  STATE_W  current state, for debug
- illegal  out  1  sticky undefined-opcode or func flag

Behaviour:
- Reset: state = FETCH, illegal = 0. All enables are 0 except mem_req.
- All outputs decode from the registered state. The only combinational inputs are zero (BRANCH) and mem_ready (FETCH, MEM_RD, MEM_WR).
- FETCH: mem_req = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 1, ALUCtr = add.
  - Holds while mem_ready = 0.
  - When mem_ready = 1: ir_write = 1, pc_write = 1 (pc_src = 0), then go to DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 3, ALUCtr = add (branch target into ALUOut). Next state by opcode:
  - 000000: EXEC_R
  - 001000 addi, 001100 andi, 001101 ori, 001010 slti, 000001 li: EXEC_I
  - 100011 lw, 101011 sw: MEM_ADDR
  - 000100 beq, 000101 bne: BRANCH
  - 000010 j, 000011 jal: JUMP
  - anything else: TRAP
- EXEC_R: alu_src_a = 1, alu_src_b = 0. ALUCtr from func:
  - 100000 add, 100010 sub, 100100 and, 011000 or, 101010 slt, 000000 sll, 000010 srl, then go to WB_R.
  - 001000 jr: pc_write = 1, pc_src = 3, then go to FETCH.
  - Any other func: go to TRAP.
- EXEC_I: alu_src_a = 1, alu_src_b = 2. ALUCtr: addi/li add, andi and, ori or, slti slt. Then go to WB_I.
- WB_R: reg_wr = 1, reg_dst = 1, mem_to_reg = 0, then go to FETCH.
- WB_I: reg_wr = 1, reg_dst = 0, mem_to_reg = 0, then go to FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, ALUCtr = add. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req = 1, i_or_d = 1. Holds until mem_ready = 1 (MDR captures that cycle), then go to WB_MEM.
- MEM_WR: mem_req = 1, mem_we = 1, i_or_d = 1. Holds until mem_ready = 1, then go to FETCH.
- WB_MEM: reg_wr = 1, reg_dst = 0, mem_to_reg = 1, then go to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, ALUCtr = sub, pc_src = 1.
  - pc_write = zero for beq, pc_write = !zero for bne.
  - Then go to FETCH.
- JUMP: pc_write = 1, pc_src = 2. For jal also reg_wr = 1, reg_dst = 2, mem_to_reg = 2. Then go to FETCH.
- TRAP: illegal = 1. All enables and mem_req = 0. Stays in TRAP until rst.
- Latency in cycles, excluding memory wait states:
  - R-type and I-type: 4
  - lw: 5
  - sw: 4
  - beq, bne, j, jal, jr: 3
- Each memory wait adds exactly one cycle. mem_req stays high and the other outputs stay constant while waiting.
- rst in any state, including mid memory wait, forces FETCH on the next edge and clears illegal. The aborted request is dropped: mem_req reasserts with i_or_d = 0.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.

Test Plan:
- add (op 000000, func 100000), mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, WB_R; reg_wr = 1 with reg_dst = 1 in cycle 4; back in FETCH in cycle 5.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD -> total 10 cycles; ir_write pulses once; reg_wr = 1 and mem_to_reg = 1 only in WB_MEM.
- beq with zero = 1, then beq with zero = 0, then bne with zero = 0 -> pc_write in BRANCH is 1, 0, 1 respectively; pc_src = 1 each time.
- jal (000011) -> JUMP asserts pc_write, pc_src = 2, reg_wr, reg_dst = 2, mem_to_reg = 2; jr (func 001000) -> pc_src = 3 in EXEC_R, 3-cycle instruction.
- op 111111, and op 000000 with func 111111 -> TRAP with illegal = 1 and all enables 0 for 20 cycles; rst pulse -> FETCH with illegal = 0.
- rst asserted during MEM_WR wait -> next cycle state = FETCH, mem_we = 0, i_or_d = 0, no reg_wr glitch.
